// File: rtl/register_read_serializer_if.sv
// Handshake bundle between a word source, the read serializer and a beat sink.
// The slave modport is the serializer's view; master is the view of the
// environment that offers words and accepts beats.
interface register_read_serializer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int BEAT_WIDTH = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] Din;
    logic                  out_valid;
    logic                  out_ready;
    logic [BEAT_WIDTH-1:0] Dout;
    logic                  out_last;

    modport slave (
        input  in_valid,
        input  Din,
        input  out_ready,
        output in_ready,
        output out_valid,
        output Dout,
        output out_last
    );

    modport master (
        output in_valid,
        output Din,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  Dout,
        input  out_last
    );
endinterface

// File: rtl/register_read_serializer.sv
// Read-side serializer: takes a full word from a storage register and drains
// it as narrow beats, least-significant beat first, with per-beat flow control,
// last-beat marking and bubble-free back-to-back word acceptance.
module register_read_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int BEAT_WIDTH = 8
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic                        EN,
    register_read_serializer_if.slave   bus,
    output logic                        busy
);
    localparam int BEATS = DATA_WIDTH / BEAT_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]            state_r;
    logic [0:0]            state_n_s;
    logic [CNT_W-1:0]      cnt_r;
    logic [CNT_W-1:0]      cnt_n_s;
    logic [DATA_WIDTH-1:0] shreg_r;
    logic [DATA_WIDTH-1:0] shreg_n_s;

    logic cnt_last_s;
    logic out_valid_s;
    logic take_s;
    logic in_ready_s;
    logic acc_s;

    // Handshake qualifiers; out_ready feeds in_ready so a finishing word can
    // hand over to the next one in the same cycle.
    always_comb begin
        cnt_last_s  = (cnt_r == CNT_LAST);
        out_valid_s = EN & (state_r == SHIFT);
        take_s      = out_valid_s & bus.out_ready;
        in_ready_s  = EN & ((state_r == IDLE) | (take_s & cnt_last_s));
        acc_s       = EN & bus.in_valid & in_ready_s;
    end

    // Next-state selection: load on accept, shift on each consumed beat,
    // reload or retire after the final beat, hold otherwise.
    always_comb begin
        state_n_s = state_r;
        cnt_n_s   = cnt_r;
        shreg_n_s = shreg_r;
        if (!EN) begin
            state_n_s = state_r;
        end else begin
            case (state_r)
                IDLE: begin
                    if (acc_s) begin
                        shreg_n_s = bus.Din;
                        cnt_n_s   = CNT_ZERO;
                        state_n_s = SHIFT;
                    end else begin
                        state_n_s = IDLE;
                    end
                end
                SHIFT: begin
                    if (take_s && !cnt_last_s) begin
                        shreg_n_s = shreg_r >> BEAT_WIDTH;
                        cnt_n_s   = cnt_r + CNT_W'(1);
                    end else if (take_s && acc_s) begin
                        shreg_n_s = bus.Din;
                        cnt_n_s   = CNT_ZERO;
                        state_n_s = SHIFT;
                    end else if (take_s) begin
                        cnt_n_s   = CNT_ZERO;
                        state_n_s = IDLE;
                    end else begin
                        state_n_s = SHIFT;
                    end
                end
                default: begin
                    state_n_s = IDLE;
                    cnt_n_s   = CNT_ZERO;
                    shreg_n_s = {DATA_WIDTH{1'b0}};
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            shreg_r <= {DATA_WIDTH{1'b0}};
        end else begin
            state_r <= state_n_s;
            cnt_r   <= cnt_n_s;
            shreg_r <= shreg_n_s;
        end
    end

    // Outputs: the beat comes straight off the shift register so it stays
    // stable under backpressure; busy ignores EN so a frozen word is visible.
    always_comb begin
        bus.in_ready  = in_ready_s;
        bus.out_valid = out_valid_s;
        bus.Dout      = shreg_r[BEAT_WIDTH-1:0];
        bus.out_last  = out_valid_s & cnt_last_s;
        busy          = (state_r == SHIFT);
    end
endmodule
